// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor bit positions, debounce FSM states.
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  localparam int FLOOR1 = 0;
  localparam int FLOOR2 = 1;
  localparam int FLOOR3 = 2;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    HELD  = 2'd2,
    RWAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/call_panel_if.sv
// Raw buttons and door acknowledges in, latched request lamps out.
// The master modport is the board/controller side; the slave modport is call_panel.
interface call_panel_if #(
  parameter int N = elevator_pkg::NUM_FLOORS
);

  logic [N-1:0] btn_interior;
  logic [N-1:0] btn_exterior;
  logic [N-1:0] doors;
  logic [N-1:0] interior_panel;
  logic [N-1:0] exterior_panel;
  logic         req_pending;

  modport master (
    output btn_interior, btn_exterior, doors,
    input  interior_panel, exterior_panel, req_pending
  );

  modport slave (
    input  btn_interior, btn_exterior, doors,
    output interior_panel, exterior_panel, req_pending
  );

endinterface

// File: rtl/call_debounce.sv
// One button: 2-flop synchroniser then REL/PWAIT/HELD/RWAIT debounce, single-cycle press pulse.
// Latency: stable press to pulse is 2 + DEBOUNCE_CYCLES cycles; no backpressure, pulse is fire-and-forget.
module call_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      REL: begin
        if (sync2_q) begin
          state_d = PWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PWAIT: begin
        if (!sync2_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          press   = 1'b1;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RWAIT: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= REL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/call_panel.sv
// Debounced car/hall call latches cleared by door-open; CALL_CANCEL_EN adds car-call cancel on re-press.
// Latency: raw press to lamp 3 + DEBOUNCE_CYCLES cycles, door to clear 1 cycle; no backpressure.
module call_panel #(
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         CLK,
  input  logic         RST,
  call_panel_if.slave  pnl
);

  logic [NUM_FLOORS-1:0] press_int;
  logic [NUM_FLOORS-1:0] press_ext;
  logic [NUM_FLOORS-1:0] int_req_q, int_req_d;
  logic [NUM_FLOORS-1:0] ext_req_q, ext_req_d;
  logic                  req_pending_q, req_pending_d;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_int (
      .CLK    (CLK),
      .RST    (RST),
      .btn_raw(pnl.btn_interior[i]),
      .press  (press_int[i])
    );

    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ext (
      .CLK    (CLK),
      .RST    (RST),
      .btn_raw(pnl.btn_exterior[i]),
      .press  (press_ext[i])
    );
  end

  // An open door both clears the floor and swallows any press landing that cycle.
  always_comb begin
`ifdef CALL_CANCEL_EN
    int_req_d = (int_req_q ^ press_int) & ~pnl.doors;
`else
    int_req_d = (int_req_q | press_int) & ~pnl.doors;
`endif
    ext_req_d     = (ext_req_q | press_ext) & ~pnl.doors;
    req_pending_d = |{int_req_d, ext_req_d};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      int_req_q     <= '0;
      ext_req_q     <= '0;
      req_pending_q <= 1'b0;
    end else begin
      int_req_q     <= int_req_d;
      ext_req_q     <= ext_req_d;
      req_pending_q <= req_pending_d;
    end
  end

  assign pnl.interior_panel = int_req_q;
  assign pnl.exterior_panel = ext_req_q;
  assign pnl.req_pending    = req_pending_q;

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel with DEBOUNCE_CYCLES=4; expectations follow the CALL_CANCEL_EN build setting.
module tb_call_panel;
  import elevator_pkg::*;

  localparam int N = 3;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST;
  int   compared   = 0;
  int   mismatched = 0;

  call_panel_if #(.N(N)) bus ();

  call_panel #(
    .NUM_FLOORS     (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pnl(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ei, input logic [2:0] ee, input logic ep);
    chk({tag, "_int"}, 32'(bus.interior_panel), 32'(ei));
    chk({tag, "_ext"}, 32'(bus.exterior_panel), 32'(ee));
    chk({tag, "_pend"}, 32'(bus.req_pending), 32'(ep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST              = 1'b1;
    bus.btn_interior = '0;
    bus.btn_exterior = '0;
    bus.doors        = '0;
    tick(3);
    RST = 1'b0;
    chk_all("reset", 3'b000, 3'b000, 1'b0);
    tick(5);
    chk_all("idle", 3'b000, 3'b000, 1'b0);

    // Floor 3 car press: lamp appears exactly 7 cycles after the press.
    bus.btn_interior = 3'b100;
    tick(6);
    chk_all("press_early", 3'b000, 3'b000, 1'b0);
    tick(1);
    chk_all("press_lat", 3'b100, 3'b000, 1'b1);
    tick(3);
    bus.btn_interior = 3'b000;
    tick(8);
    chk_all("press_hold", 3'b100, 3'b000, 1'b1);

    bus.doors = 3'b100;
    tick(1);
    chk_all("door_clr", 3'b000, 3'b000, 1'b0);
    bus.doors = 3'b000;

    // Single-cycle bounces on hall floor 1 never qualify.
    bus.btn_exterior[FLOOR1] = 1'b1; tick(1);
    bus.btn_exterior[FLOOR1] = 1'b0; tick(1);
    bus.btn_exterior[FLOOR1] = 1'b1; tick(1);
    bus.btn_exterior[FLOOR1] = 1'b0;
    tick(12);
    chk_all("glitch", 3'b000, 3'b000, 1'b0);

    bus.btn_interior = 3'b110;
    tick(7);
    chk_all("two_lat", 3'b110, 3'b000, 1'b1);
    bus.btn_interior = 3'b000;
    tick(8);
    bus.doors = 3'b010;
    tick(1);
    chk_all("door_f2", 3'b100, 3'b000, 1'b1);
    bus.btn_interior = 3'b010;
    tick(10);
    chk_all("press_in_door", 3'b100, 3'b000, 1'b1);
    bus.btn_interior = 3'b000;
    bus.doors        = 3'b000;
    tick(8);
    chk_all("after_door", 3'b100, 3'b000, 1'b1);

    RST = 1'b1;
    tick(1);
    chk_all("rst_mid", 3'b000, 3'b000, 1'b0);
    RST = 1'b0;

    bus.btn_interior = 3'b111;
    bus.btn_exterior = 3'b111;
    tick(6);
    chk_all("all_early", 3'b000, 3'b000, 1'b0);
    tick(1);
    chk_all("all_lat", 3'b111, 3'b111, 1'b1);
    bus.btn_interior = 3'b000;
    bus.btn_exterior = 3'b000;
    tick(8);

    bus.doors = 3'b111;
    tick(1);
    chk_all("doors_all", 3'b000, 3'b000, 1'b0);
    bus.doors = 3'b000;

    // Reset mid-debounce with the button still held: a full fresh debounce is required.
    bus.btn_interior = 3'b001;
    tick(3);
    RST = 1'b1;
    tick(1);
    chk_all("rst_deb", 3'b000, 3'b000, 1'b0);
    RST = 1'b0;
    tick(6);
    chk_all("redeb_early", 3'b000, 3'b000, 1'b0);
    tick(1);
    chk_all("redeb_lat", 3'b001, 3'b000, 1'b1);
    bus.btn_interior = 3'b000;
    tick(8);

    bus.btn_exterior = 3'b001;
    tick(7);
    chk_all("ext_lat", 3'b001, 3'b001, 1'b1);
    bus.btn_exterior = 3'b000;
    tick(8);

    bus.btn_interior = 3'b001;
    bus.btn_exterior = 3'b001;
    tick(7);
`ifdef CALL_CANCEL_EN
    chk_all("repress", 3'b000, 3'b001, 1'b1);
`else
    chk_all("repress", 3'b001, 3'b001, 1'b1);
`endif
    bus.btn_interior = 3'b000;
    bus.btn_exterior = 3'b000;
    tick(8);
`ifdef CALL_CANCEL_EN
    chk_all("repress_hold", 3'b000, 3'b001, 1'b1);
`else
    chk_all("repress_hold", 3'b001, 3'b001, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
